// File: rtl/cnn_pkg.sv
// Shared FSM encoding and sweep-size helper for the convolution window controller.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned window_count(input int unsigned img_w,
                                                 input int unsigned img_h,
                                                 input int unsigned k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Combinational fan-out of a window base offset into K*K buffer read addresses.
module win_addr_gen #(
    parameter int unsigned K          = 5,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_WIDTH-1:0]     base,
    output logic [K*K*ADDR_WIDTH-1:0] rd_addr_NP
);

    always_comb begin
        rd_addr_NP = '0;
        for (int unsigned ky = 0; ky < K; ky++) begin
            for (int unsigned kx = 0; kx < K; kx++) begin
                rd_addr_NP[(ky*K + kx)*ADDR_WIDTH +: ADDR_WIDTH] =
                    BASE_ADDR + base + ADDR_WIDTH'(ky*IMG_W + kx);
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Row-major sliding-window sweep controller with valid/ready handshake and
// per-tap buffer read addresses.
module conv_window_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned K          = 5,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      win_ready,
    output logic                      win_valid,
    output logic [K*K*ADDR_WIDTH-1:0] rd_addr_NP,
    output logic [15:0]               win_row,
    output logic [15:0]               win_col,
    output logic                      win_last,
    output logic                      busy,
    output logic                      done
);

    if (K > IMG_W || K > IMG_H) begin : g_bad_kernel
        $error("conv_window_ctrl: kernel side K exceeds image dimensions");
    end

    localparam logic [15:0] LAST_COL = 16'(IMG_W - K);
    localparam logic [15:0] LAST_ROW = 16'(IMG_H - K);

    state_t                  state, state_next;
    logic [15:0]             row_next, col_next;
    logic [ADDR_WIDTH-1:0]   base, base_next;
    logic                    xfer, at_last;

    assign win_valid = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign at_last   = (win_row == LAST_ROW) && (win_col == LAST_COL);
    assign win_last  = win_valid && at_last;
    assign xfer      = win_valid && win_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            win_row <= '0;
            win_col <= '0;
            base    <= '0;
        end else begin
            state   <= state_next;
            win_row <= row_next;
            win_col <= col_next;
            base    <= base_next;
        end
    end

    // base tracks win_row*IMG_W+win_col incrementally: +1 along a row, +K on wrap
    always_comb begin
        state_next = state;
        row_next   = win_row;
        col_next   = win_col;
        base_next  = base;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    row_next   = '0;
                    col_next   = '0;
                    base_next  = '0;
                end else if (xfer) begin
                    if (at_last) begin
                        state_next = ST_DONE;
                        row_next   = '0;
                        col_next   = '0;
                        base_next  = '0;
                    end else if (win_col == LAST_COL) begin
                        row_next  = win_row + 16'd1;
                        col_next  = '0;
                        base_next = base + ADDR_WIDTH'(K);
                    end else begin
                        col_next  = win_col + 16'd1;
                        base_next = base + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    win_addr_gen #(
        .K          (K),
        .IMG_W      (IMG_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr (
        .base       (base),
        .rd_addr_NP (rd_addr_NP)
    );

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench: window-index reference model compared every cycle,
// plus directed literal checks of sweep boundaries, stall, abort and reset.
module tb_conv_window_ctrl;

    localparam int unsigned W     = 28;
    localparam int unsigned H     = 28;
    localparam int unsigned KS    = 5;
    localparam int unsigned AW    = 32;
    localparam logic [AW-1:0] BA  = '0;
    localparam int unsigned NW    = W - KS + 1;
    localparam int unsigned NH    = H - KS + 1;
    localparam int unsigned TOTAL = NW * NH;
    localparam int unsigned NP    = KS * KS;

    logic               clk, rst, start, abort, win_ready;
    logic               win_valid, win_last, busy, done;
    logic [NP*AW-1:0]   rd_addr_NP;
    logic [15:0]        win_row, win_col;

    conv_window_ctrl #(
        .IMG_W      (W),
        .IMG_H      (H),
        .K          (KS),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .win_ready  (win_ready),
        .win_valid  (win_valid),
        .rd_addr_NP (rd_addr_NP),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_last   (win_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] port(input int unsigned p);
        return rd_addr_NP[p*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int unsigned n, input int unsigned p);
        int unsigned r, c;
        r = n / NW;
        c = n % NW;
        return AW'(BA + (r + p / KS) * W + c + p % KS);
    endfunction

    // Reference model: 0 = idle, 1 = sweeping, 2 = completion cycle; m_n = window index
    int          m_mode = 0;
    int unsigned m_n    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_n    <= 0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode <= 1; m_n <= 0; end
                1: begin
                    if (abort) begin
                        m_mode <= 0;
                        m_n    <= 0;
                    end else if (win_ready) begin
                        if (m_n == TOTAL - 1) begin
                            m_mode <= 2;
                            m_n    <= 0;
                        end else begin
                            m_n <= m_n + 1;
                        end
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    int bad_p;
    always @(negedge clk) begin
        chk("win_valid", win_valid, (m_mode == 1));
        chk("busy", busy, (m_mode != 0));
        chk("done", done, (m_mode == 2));
        chk("win_row", win_row, m_n / NW);
        chk("win_col", win_col, m_n % NW);
        chk("win_last", win_last, (m_mode == 1) && (m_n == TOTAL - 1));
        bad_p = -1;
        for (int p = NP - 1; p >= 0; p--)
            if (port(p) !== exp_addr(m_n, p)) bad_p = p;
        n_cmp++;
        if (bad_p >= 0) begin
            n_bad++;
            $display("FAIL rd_addr port %0d: got %0d, expected %0d",
                     bad_p, port(bad_p), exp_addr(m_n, bad_p));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  xfers, dones, x2, d2;
    bit  fin, stalled, chk26, seen_wrap, seen_last;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", win_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_port0", port(0), 0);
        chk("rst_port24", port(24), 116);
        rst = 1'b0;
        tick();

        // Full sweep with always-ready consumer, a stall at (2,5) and a stray start
        start = 1'b1; win_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("first_valid", win_valid, 1);
        chk("first_port0", port(0), 0);
        chk("first_port4", port(4), 4);
        chk("first_port5", port(5), 28);
        chk("first_port24", port(24), 116);
        xfers = 0; dones = 0; fin = 0; stalled = 0; chk26 = 0; seen_wrap = 0; seen_last = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (done) begin
                dones++;
                chk("busy_in_done", busy, 1);
                tick();
                chk("busy_after_done", busy, 0);
                repeat (5) begin
                    tick();
                    if (done) dones++;
                end
                fin = 1;
                break;
            end
            if (chk26) begin
                chk("after_stall_row", win_row, 2);
                chk("after_stall_col", win_col, 6);
                chk26 = 0;
            end
            if (win_valid && win_row == 1 && win_col == 0 && !seen_wrap) begin
                seen_wrap = 1;
                chk("wrap_port0", port(0), 28);
                chk("wrap_port24", port(24), 144);
            end
            if (win_valid && win_row == 23 && win_col == 23) begin
                seen_last = 1;
                chk("last_port0", port(0), 667);
                chk("last_port24", port(24), 783);
                chk("last_flag", win_last, 1);
            end
            if (win_valid && win_row == 2 && win_col == 5 && !stalled) begin
                stalled = 1;
                win_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_row", win_row, 2);
                    chk("stall_col", win_col, 5);
                    chk("stall_port0", port(0), 61);
                    chk("stall_port24", port(24), 177);
                end
                win_ready = 1'b1;
                chk26 = 1;
            end
            start = (xfers == 10) && win_valid;
            if (win_valid && win_ready) xfers++;
            tick();
        end
        start = 1'b0;
        chk("sweep_finished", fin, 1);
        chk("sweep_xfers", xfers, 576);
        chk("done_pulses", dones, 1);
        chk("saw_last_window", seen_last, 1);

        // Abort at window 100 with a simultaneous transfer
        start = 1'b1; win_ready = 1'b1;
        tick();
        start = 1'b0;
        x2 = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (win_valid && x2 == 100) break;
            if (win_valid && win_ready) x2++;
            tick();
        end
        chk("abort_reached", x2, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", win_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_row", win_row, 0);
        chk("abort_col", win_col, 0);
        d2 = 0;
        repeat (10) begin
            if (done) d2++;
            tick();
        end
        chk("abort_no_done", d2, 0);

        // Reset mid-sweep takes effect without a clock edge
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", win_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_row", win_row, 0);
        chk("midrst_col", win_col, 0);
        chk("midrst_port24", port(24), 116);
        tick(); tick();
        rst = 1'b0;
        d2 = 0;
        repeat (10) begin
            tick();
            if (done) d2++;
        end
        chk("midrst_no_done", d2, 0);

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 6000; cyc++) begin
            start     = ($urandom % 8) == 0;
            win_ready = ($urandom % 4) != 0;
            abort     = ($urandom % 400) == 0;
            rst       = ($urandom % 2000) == 0;
            tick();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter K, default 5, square kernel side; port count = K*K.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, buffer address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0, buffer address of pixel (0,0).
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  one-cycle request to begin a full window sweep.
REQ-010 abort  input  1  synchronous request to stop the sweep without done.
REQ-011 win_ready  input  1  consumer accepts the current window.
REQ-012 win_valid  output  1  rd_addr_NP holds a valid window.
REQ-013 rd_addr_NP  output  K*K*ADDR_WIDTH  flattened read addresses to the data buffer; port i occupies bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
REQ-014 win_row, win_col  output  16 each  top-left coordinate of the current window.
REQ-015 win_last  output  1  current window is the final one of the sweep.
REQ-016 busy  output  1  sweep in progress.
REQ-017 done  output  1  one-cycle pulse after the final window is accepted.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 IDLE->RUN on start=1; the first window (0,0) SHALL have win_valid=1 in the next cycle.
REQ-020 Window port i=ky*K+kx SHALL carry BASE_ADDR + (win_row+ky)*IMG_W + win_col + kx, modulo 2^ADDR_WIDTH.
REQ-021 Addresses SHALL derive only from registered state (base = win_row*IMG_W+win_col) and be stable whenever win_valid=1 and win_ready=0.
REQ-022 Transfer SHALL occur only when win_valid=1 and win_ready=1; each transfer advances exactly one window.
REQ-023 Advance order is row-major: win_col increments; at win_col=IMG_W-K it wraps to 0 and win_row increments.
REQ-024 win_last SHALL be 1 exactly when win_row=IMG_H-K and win_col=IMG_W-K.
REQ-025 A transfer with win_last=1 SHALL go RUN->DONE; DONE SHALL assert done=1 for one cycle, deassert win_valid, then return to IDLE.
REQ-026 Total transfers per sweep = (IMG_W-K+1)*(IMG_H-K+1).
REQ-027 start SHALL be ignored while busy=1 or in DONE.
REQ-028 abort in RUN SHALL return to IDLE next cycle with done=0, coordinates cleared, and win_valid=0; abort SHALL take priority over a simultaneous transfer.
REQ-029 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-030 If K > IMG_W or K > IMG_H, elaboration SHALL fail.

Reset
REQ-031 While rst=1, the block SHALL hold the following regardless of clk: state=IDLE, win_row=win_col=0, base=0, win_valid=0, win_last=0, busy=0, done=0, and rd_addr_NP = window (0,0) addresses.
REQ-032 Reset mid-sweep SHALL discard progress; no done pulse SHALL follow.

Structure
REQ-033 State encodings and the window-count function SHALL live in shared package cnn_pkg.
REQ-034 Address fan-out SHALL be sub-module win_addr_gen (base in -> K*K addresses out, purely combinational).

Verification
REQ-035 Defaults, start, win_ready=1 -> first window port0=0, port4=4, port5=28, port24=116; 576 transfers; done pulses once.
REQ-036 Wrap: accept window (0,23) -> next window (1,0), port0=28, port24=144.
REQ-037 Last window (23,23) -> port0=667, port24=783, win_last=1; next cycle done=1, busy=1; following cycle busy=0.
REQ-038 win_ready=0 for 3 cycles at window (2,5) -> rd_addr_NP, win_row and win_col remain unchanged; the next transfer yields (2,6).
REQ-039 start pulsed at window 10 -> ignored; abort at window 100 -> IDLE, no done; rst asserted mid-sweep -> all outputs at reset values immediately.
